stream_demux_1xn: RTL and testbench
===================================

STREAM_DEMUX_1XN -- requirements
Module: stream_demux_1xn

Interface
REQ-001 Parameter N, default 8: number of output channels; legal range 2..64.
REQ-002 Parameter WIDTH, default 8: data width per word; legal range 1..256.
REQ-003 Derived constant SEL_W = max(1, clog2(N)); not overridable.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  input word present.
REQ-007 in_ready  output  1  input word accepted this cycle when in_valid & in_ready.
REQ-008 in_data  input  WIDTH  input word.
REQ-009 in_sel  input  SEL_W  target channel for unicast.
REQ-010 mode  input  1  0 = unicast to in_sel, 1 = broadcast to all N channels; sampled only on accept.
REQ-011 out_valid  output  N  per-channel word present.
REQ-012 out_ready  input  N  per-channel consumer ready.
REQ-013 out_data  output  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-014 err_sel  output  1  one-cycle pulse: an out-of-range in_sel was accepted and dropped.
REQ-015 drop_cnt  output  8  count of dropped words, saturating at 255.

Function
REQ-016 Each channel SHALL hold a one-entry register (valid + data); out_valid[k] and out_data[k] SHALL be driven directly from it.
REQ-017 Channel k is "free" when its valid is 0 or out_ready[k] is 1 in the same cycle.
REQ-018 Unicast: in_ready SHALL be 1 when in_sel < N and channel in_sel is free, or when in_sel >= N.
REQ-019 Broadcast: in_ready SHALL be 1 only when all N channels are free, regardless of in_sel.
REQ-020 in_ready SHALL depend combinationally only on mode, in_sel, channel valids and out_ready; it SHALL NOT depend on in_valid.
REQ-021 Latency SHALL be 1 cycle: a word accepted at edge t SHALL appear on out_valid/out_data after edge t.
REQ-022 A channel SHALL sustain 1 word per cycle when out_ready is held at 1, including a simultaneous drain and reload in the same cycle.
REQ-023 A channel word SHALL stay stable while out_valid[k]=1 and out_ready[k]=0.
REQ-024 The channel valid bit SHALL clear on drain (out_valid[k] & out_ready[k]) unless the channel is reloaded in the same cycle.
REQ-025 Broadcast accept SHALL load in_data into all N channels on the same edge.
REQ-026 Unicast accept with in_sel >= N (possible only when N is not a power of 2) SHALL be dropped.
   - No channel changes.
   - err_sel is 1 on the following cycle only.
   - drop_cnt increments by 1, holding at 255.
REQ-027 Channels not targeted by an accept SHALL be unaffected apart from their own drain.
REQ-028 mode and in_sel changes while in_valid=0 SHALL have no effect on state.

Reset
REQ-029 While rst=1 at an edge, the following SHALL be 0 after that edge, regardless of in_valid/out_ready: all out_valid, all out_data, err_sel, drop_cnt.
REQ-030 Words held in channels when rst asserts mid-operation SHALL be discarded, not delivered.
REQ-031 in_ready SHALL evaluate normally during reset; any accept in a reset cycle SHALL be discarded.

Structure
REQ-032 Shared package demux_pkg SHALL hold the mode encoding (MODE_UNICAST=0, MODE_BROADCAST=1) and DROP_CNT_W=8.
REQ-033 The per-channel register SHALL be a sub-module demux_chan_reg, instantiated N times via generate.
   - Ports: clk, rst, load, drain, d, valid, q.

Verification
REQ-034 Unicast with N=8 and WIDTH=8, all out_ready=1:
   - Stimulus: send 0xA5 with in_sel=3.
   - Response: next cycle out_valid=8'b0000_1000 and channel 3 data=0xA5; one cycle later out_valid=0.
REQ-035 Backpressure with out_ready[5]=0:
   - Stimulus: send 0x11 then 0x22 to channel 5.
   - Response: in_ready=0 on the second word and 0x11 is held.
   - Then raise out_ready[5]: 0x11 drains and 0x22 loads in the same cycle.
REQ-036 Broadcast with out_ready[2]=0 and channel 2 full:
   - Stimulus: send 0x7E with mode=1.
   - Response: in_ready=0 until out_ready[2]=1.
   - Then all 8 channels show 0x7E on the next cycle.
REQ-037 Out-of-range drop with N=6:
   - Stimulus: send in_sel=7 three times.
   - Response: in_ready=1 each time, no out_valid, err_sel pulses 3 times, drop_cnt=3.
   - With 300 drops, drop_cnt=255.
REQ-038 Reset mid-stream:
   - Stimulus: channels 0 and 7 full with out_ready=0; assert rst for 1 cycle.
   - Response: out_valid=0, out_data=0, drop_cnt=0; the next accept delivers normally.
REQ-039 Throughput:
   - Stimulus: 100 back-to-back words round-robin across channels, all out_ready=1.
   - Response: in_ready stays 1; all 100 words are delivered in order per channel with 1-cycle latency.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-N stream demultiplexer: mode encoding and
// drop-counter sizing.
package demux_pkg;

    typedef enum logic {
        MODE_UNICAST   = 1'b0,
        MODE_BROADCAST = 1'b1
    } mode_e;

    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry output channel register (valid + data). A load wins over a drain,
// so a drain and a reload on the same edge keep the channel full.
module demux_chan_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    logic             r_valid;
    logic [WIDTH-1:0] r_q;

    // Data is held after a drain; only valid says whether it is meaningful.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_q     <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_q     <= d;
        end else if (drain) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign q     = r_q;

endmodule

// File: rtl/stream_demux_1xn.sv
// 1-to-N valid/ready stream demultiplexer with unicast and broadcast modes and
// a saturating counter of words dropped for an out-of-range channel select.
//
// Handshake: a word moves when valid and ready are both 1 on a rising edge.
// in_ready never looks at in_valid; each out_valid[k] is held with stable
// data until out_ready[k] is seen high.
module stream_demux_1xn
    import demux_pkg::*;
#(
    parameter int  N     = 8,
    parameter int  WIDTH = 8,
    localparam int SEL_W = (N > 2) ? $clog2(N) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  mode,
    output logic [N-1:0]          out_valid,
    input  logic [N-1:0]          out_ready,
    output logic [N*WIDTH-1:0]    out_data,
    output logic                  err_sel,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    logic [N-1:0]          w_valid;
    logic [N-1:0]          w_free;
    logic [N-1:0]          w_hit;
    logic [N-1:0]          w_load;
    logic [N-1:0]          w_drain;
    logic                  w_bcast;
    logic                  w_sel_in_range;
    logic                  w_accept;
    logic                  w_drop;
    logic                  r_err_sel;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    always_comb begin
        w_free         = ~w_valid | out_ready;
        w_drain        = w_valid & out_ready;
        w_bcast        = (mode_e'(mode) == MODE_BROADCAST);
        w_sel_in_range = (int'(in_sel) < N);
        w_hit          = '0;
        for (int k = 0; k < N; k++) begin
            w_hit[k] = (int'(in_sel) == k);
        end
        // An out-of-range unicast is always accepted so it can be discarded.
        if (w_bcast) begin
            in_ready = &w_free;
        end else if (w_sel_in_range) begin
            in_ready = |(w_free & w_hit);
        end else begin
            in_ready = 1'b1;
        end
        w_accept = in_valid & in_ready;
        w_load   = '0;
        if (w_accept) begin
            w_load = w_bcast ? {N{1'b1}} : w_hit;
        end
        w_drop = w_accept & ~w_bcast & ~w_sel_in_range;
    end

    for (genvar k = 0; k < N; k++) begin : g_chan
        demux_chan_reg #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk  (clk),
            .rst  (rst),
            .load (w_load[k]),
            .drain(w_drain[k]),
            .d    (in_data),
            .valid(w_valid[k]),
            .q    (out_data[k*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sel  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_err_sel <= w_drop;
            if (w_drop && (r_drop_cnt != DROP_CNT_MAX)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign out_valid = w_valid;
    assign err_sel   = r_err_sel;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Lockstep check of an N=8 and an N=6 demux against a channel-level model,
// with a per-channel expected queue confirming delivery order on the N=8 part.
module tb_stream_demux_1xn;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        mode;
    logic [7:0]  in_data;
    logic [2:0]  in_sel;
    logic [7:0]  out_ready;

    logic        in_ready8;
    logic [7:0]  out_valid8;
    logic [63:0] out_data8;
    logic        err8;
    logic [7:0]  cnt8;

    logic        in_ready6;
    logic [5:0]  out_valid6;
    logic [47:0] out_data6;
    logic        err6;
    logic [7:0]  cnt6;

    int n_checks = 0;
    int n_fail   = 0;
    logic last_rdy8;

    // Reference model: index 0 is the N=8 part, index 1 the N=6 part.
    int         nm[2] = '{8, 6};
    logic       mv[2][8];
    logic [7:0] md[2][8];
    logic       m_err[2];
    int         m_cnt[2];
    logic [7:0] exp_q[8][$];

    stream_demux_1xn #(.N(8), .WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(in_data), .in_sel(in_sel), .mode(mode),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8),
        .err_sel(err8), .drop_cnt(cnt8)
    );

    stream_demux_1xn #(.N(6), .WIDTH(8)) dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6),
        .in_data(in_data), .in_sel(in_sel), .mode(mode),
        .out_valid(out_valid6), .out_ready(out_ready[5:0]), .out_data(out_data6),
        .err_sel(err6), .drop_cnt(cnt6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic m_ready(int m);
        int sel = int'(in_sel);
        if (mode) begin
            for (int k = 0; k < nm[m]; k++)
                if (mv[m][k] && !out_ready[k]) return 1'b0;
            return 1'b1;
        end
        if (sel >= nm[m]) return 1'b1;
        return !mv[m][sel] || out_ready[sel];
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 8; k++) begin
                mv[m][k] = 1'b0;
                md[m][k] = 8'h00;
            end
            m_err[m] = 1'b0;
            m_cnt[m] = 0;
        end
        for (int k = 0; k < 8; k++) exp_q[k].delete();
    endtask

    // Inputs are already set (just after a falling edge); run one clock.
    task automatic tick();
        logic       rdy[2];
        logic       acc;
        logic [63:0] ev;
        logic [63:0] ed;
        #1;
        rdy[0] = m_ready(0);
        rdy[1] = m_ready(1);
        chk("in_ready8", in_ready8, rdy[0]);
        chk("in_ready6", in_ready6, rdy[1]);
        last_rdy8 = in_ready8;
        if (!rst) begin
            for (int k = 0; k < 8; k++) begin
                if (out_valid8[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0)
                        chk($sformatf("sb_spurious_ch%0d", k), out_valid8[k], 1'b0);
                    else
                        chk($sformatf("sb_order_ch%0d", k), out_data8[k*8 +: 8], exp_q[k].pop_front());
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int m = 0; m < 2; m++) begin
                acc = in_valid && rdy[m];
                for (int k = 0; k < nm[m]; k++) begin
                    if (acc && (mode || int'(in_sel) == k)) begin
                        mv[m][k] = 1'b1;
                        md[m][k] = in_data;
                        if (m == 0) exp_q[k].push_back(in_data);
                    end else if (mv[m][k] && out_ready[k]) begin
                        mv[m][k] = 1'b0;
                    end
                end
                m_err[m] = acc && !mode && (int'(in_sel) >= nm[m]);
                if (m_err[m] && m_cnt[m] < 255) m_cnt[m]++;
            end
        end
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            ev = '0;
            ed = '0;
            for (int k = 0; k < nm[m]; k++) begin
                ev[k] = mv[m][k];
                ed[k*8 +: 8] = md[m][k];
            end
            if (m == 0) begin
                chk("out_valid8", out_valid8, ev);
                chk("out_data8", out_data8, ed);
                chk("err_sel8", err8, m_err[0]);
                chk("drop_cnt8", cnt8, m_cnt[0]);
            end else begin
                chk("out_valid6", out_valid6, ev);
                chk("out_data6", out_data6, ed);
                chk("err_sel6", err6, m_err[1]);
                chk("drop_cnt6", cnt6, m_cnt[1]);
            end
        end
    endtask

    task automatic send(input logic [2:0] sel, input logic [7:0] data, input logic md_b);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        mode     = md_b;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        int n_err_pulses;
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; in_data = '0; in_sel = '0;
        out_ready = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        model_reset();

        // Accept attempted during reset must be discarded.
        send(3'd1, 8'h99, 1'b0);
        chk("reset_out_valid8", out_valid8, 8'h00);
        chk("reset_drop_cnt6", cnt6, 8'd0);
        rst = 1'b0;

        // Unicast to channel 3, one-cycle latency, then drained.
        send(3'd3, 8'hA5, 1'b0);
        chk("uni_valid", out_valid8, 8'b0000_1000);
        chk("uni_data", out_data8[31:24], 8'hA5);
        idle();
        chk("uni_drained", out_valid8, 8'h00);

        // Backpressure on channel 5, then drain and reload on one edge.
        out_ready = 8'hDF;
        send(3'd5, 8'h11, 1'b0);
        send(3'd5, 8'h22, 1'b0);
        chk("bp_ready_low", last_rdy8, 1'b0);
        chk("bp_hold", out_data8[47:40], 8'h11);
        out_ready = 8'hFF;
        send(3'd5, 8'h22, 1'b0);
        chk("bp_reload_valid", out_valid8[5], 1'b1);
        chk("bp_reload_data", out_data8[47:40], 8'h22);
        idle();

        // Broadcast blocked by a full, stalled channel 2.
        out_ready = 8'hFB;
        send(3'd2, 8'h33, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send(3'd6, 8'h7E, 1'b1);
            chk("bc_blocked", last_rdy8, 1'b0);
        end
        out_ready = 8'hFF;
        send(3'd6, 8'h7E, 1'b1);
        chk("bc_ready", last_rdy8, 1'b1);
        chk("bc_valid", out_valid8, 8'hFF);
        chk("bc_data", out_data8, {8{8'h7E}});
        chk("bc_data6", out_data6, {6{8'h7E}});
        mode = 1'b0;
        idle();

        // Out-of-range select on the N=6 part: dropped and counted.
        n_err_pulses = 0;
        for (int i = 0; i < 3; i++) begin
            send(3'd7, 8'h40 + 8'(i), 1'b0);
            chk("drop_ready6", in_ready6, 1'b1);
            chk("drop_no_valid6", out_valid6, 6'h00);
            if (err6) n_err_pulses++;
        end
        idle();
        chk("drop_err_pulses", n_err_pulses, 3);
        chk("drop_cnt3", cnt6, 8'd3);
        for (int i = 0; i < 300; i++) send(3'd7, 8'($urandom), 1'b0);
        idle();
        chk("drop_cnt_sat", cnt6, 8'd255);

        // Reset with channels 0 and 7 holding stalled words.
        out_ready = 8'h00;
        send(3'd0, 8'hC0, 1'b0);
        send(3'd7, 8'hC7, 1'b0);
        chk("pre_rst_valid", out_valid8, 8'h81);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("rst_valid", out_valid8, 8'h00);
        chk("rst_data", out_data8, 64'h0);
        chk("rst_cnt6", cnt6, 8'd0);
        out_ready = 8'hFF;
        send(3'd0, 8'h5A, 1'b0);
        chk("post_rst_valid", out_valid8, 8'h01);
        chk("post_rst_data", out_data8[7:0], 8'h5A);
        idle();

        // Back-to-back round robin at full rate.
        for (int i = 0; i < 100; i++) begin
            send(3'(i % 8), 8'($urandom), 1'b0);
            chk("tput_ready", last_rdy8, 1'b1);
        end
        idle();

        // Random traffic with occasional broadcast and reset.
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            mode      = ($urandom_range(0, 7) == 0);
            in_sel    = 3'($urandom_range(0, 7));
            in_data   = 8'($urandom);
            out_ready = 8'($urandom);
            tick();
        end
        rst = 1'b0;
        mode = 1'b0;
        out_ready = 8'hFF;
        idle();
        idle();
        for (int k = 0; k < 8; k++) chk($sformatf("sb_left_ch%0d", k), exp_q[k].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
